// File: rtl/adder_pkg.sv
// Shared adder definitions: carry-select slice width, sequencer state type,
// and the signed-overflow rule used by every adder block.
package adder_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic {
    IDLE,
    BUSY
  } mwa_state_t;

  // Two's-complement overflow: both operands agree in sign and the sum disagrees.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb ^ s_msb) & (b_msb ^ s_msb);
  endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Word-stream bus of the multi-word add/sub sequencer: operand words in,
// result words out, each on its own valid/ready handshake.
interface multiword_add_seq_if #(
  parameter int unsigned N         = 32,
  parameter int unsigned MAX_WORDS = 16
);
  localparam int unsigned IDXW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_x;
  logic [N-1:0]    in_y;
  logic            in_first;
  logic            in_last;
  logic            in_sub;
  logic            in_cin;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_sum;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            out_carry;
  logic            out_overflow;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in_x, in_y, in_first, in_last, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_idx, out_last, out_carry, out_overflow
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, in_x, in_y, in_first, in_last, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_idx, out_last, out_carry, out_overflow
  );
endinterface

// File: rtl/multiword_add_seq_carrySelectAdder.sv
// N-bit carry-select adder built from SLICE_W-bit slices; every slice
// precomputes both carry-in cases and the incoming carry picks one.
module carrySelectAdder
  import adder_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         carryout_o
);
  localparam int unsigned NS = N / SLICE_W;

  logic [NS:0] c;

  assign c[0] = cin_i;

  for (genvar g = 0; g < NS; g++) begin : g_slice
    logic [SLICE_W:0] r0;
    logic [SLICE_W:0] r1;

    assign r0 = {1'b0, a_i[g*SLICE_W +: SLICE_W]} + {1'b0, b_i[g*SLICE_W +: SLICE_W]};
    assign r1 = r0 + {{SLICE_W{1'b0}}, 1'b1};
    assign sum_o[g*SLICE_W +: SLICE_W] = c[g] ? r1[SLICE_W-1:0] : r0[SLICE_W-1:0];
    assign c[g+1] = c[g] ? r1[SLICE_W] : r0[SLICE_W];
  end

  assign carryout_o = c[NS];
endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision add/sub sequencer: streams N-bit word pairs (LS first)
// through one carry-select adder, chaining the registered carry between words.
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus,
  output logic                seq_err
);
  localparam int unsigned IDXW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  mwa_state_t      state_q, state_d;
  logic            carry_q;
  logic            sub_q;
  logic            out_valid_q;
  logic [N-1:0]    out_sum_q;
  logic [IDXW-1:0] out_idx_q;
  logic            out_last_q;
  logic            out_carry_q;
  logic            out_overflow_q;
  logic            seq_err_q;

  logic            in_ready;
  logic            accept;
  logic            first;
  logic            sub;
  logic [N-1:0]    yw;
  logic            cin;
  logic [N-1:0]    sum;
  logic            cout;
  logic [IDXW-1:0] idx_nxt;
  logic            overlimit;
  logic            ovf;

  assign in_ready  = ~out_valid_q | bus.out_ready;
  assign accept    = bus.in_valid & in_ready;
  assign first     = (state_q == IDLE) | bus.in_first;
  assign sub       = first ? bus.in_sub : sub_q;
  assign yw        = bus.in_y ^ {N{sub}};
  assign cin       = first ? (sub | bus.in_cin) : carry_q;
  assign idx_nxt   = first ? '0 : out_idx_q + IDXW'(1);
  assign overlimit = (idx_nxt == IDXW'(MAX_WORDS - 1)) & ~bus.in_last;
  assign ovf       = bus.in_last & signed_ovf(bus.in_x[N-1], yw[N-1], sum[N-1]);

  carrySelectAdder #(.N(N)) u_add (
    .a_i        (bus.in_x),
    .b_i        (yw),
    .cin_i      (cin),
    .sum_o      (sum),
    .carryout_o (cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: an accepted last word, or one that hits the word limit, ends the op.
  always_comb begin
    state_d = state_q;
    if (accept) state_d = (bus.in_last | overlimit) ? IDLE : BUSY;
  end

  // Carry/sub chaining and single-entry output register (reload on pop+accept, no bubble).
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q        <= 1'b0;
      sub_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_idx_q      <= '0;
      out_last_q     <= 1'b0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
    end else if (accept) begin
      carry_q        <= cout;
      sub_q          <= sub;
      out_valid_q    <= 1'b1;
      out_sum_q      <= sum;
      out_idx_q      <= idx_nxt;
      out_last_q     <= bus.in_last;
      out_carry_q    <= cout;
      out_overflow_q <= ovf;
    end else if (out_valid_q & bus.out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  // Sticky over-length flag.
  always_ff @(posedge clk) begin
    if (rst)                     seq_err_q <= 1'b0;
    else if (accept & overlimit) seq_err_q <= 1'b1;
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_idx      = out_idx_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_carry    = out_carry_q;
  assign bus.out_overflow = out_overflow_q;
  assign seq_err          = seq_err_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (N=8, MAX_WORDS=4) with a queue scoreboard.
module tb_multiword_add_seq;
  localparam int unsigned N  = 8;
  localparam int unsigned MW = 4;

  typedef struct {
    logic [7:0] sum;
    logic [1:0] idx;
    logic       last;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic seq_err;

  always #5 clk = ~clk;

  multiword_add_seq_if #(.N(N), .MAX_WORDS(MW)) bus ();

  multiword_add_seq #(.N(N), .MAX_WORDS(MW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .seq_err (seq_err)
  );

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // reference state of the operation in progress
  logic       m_busy  = 1'b0;
  logic       m_carry = 1'b0;
  logic       m_sub   = 1'b0;
  int         m_idx   = 0;
  logic       m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_accept(input logic [7:0] x, input logic [7:0] y,
                              input logic f, input logic l, input logic s, input logic c);
    logic       fst, sb_sub, ci, err;
    logic [7:0] yw;
    logic [8:0] r;
    int         idx;
    exp_t       e;
    fst    = !m_busy || f;
    sb_sub = fst ? s : m_sub;
    yw     = y ^ {8{sb_sub}};
    ci     = fst ? (sb_sub ? 1'b1 : c) : m_carry;
    r      = {1'b0, x} + {1'b0, yw} + {8'd0, ci};
    idx    = fst ? 0 : m_idx + 1;
    err    = (idx == MW - 1) && !l;
    e.sum   = r[7:0];
    e.idx   = idx[1:0];
    e.last  = l;
    e.carry = r[8];
    e.ovf   = l & (x[7] ^ r[7]) & (yw[7] ^ r[7]);
    sb.push_back(e);
    m_carry = r[8];
    m_sub   = sb_sub;
    m_idx   = idx;
    m_busy  = !(l || err);
    m_err   = m_err | err;
  endtask

  // Called at a falling edge; returns at the falling edge after the word is taken.
  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic f, input logic l, input logic s, input logic c);
    int n;
    n = 0;
    bus.in_x = x; bus.in_y = y; bus.in_first = f; bus.in_last = l;
    bus.in_sub = s; bus.in_cin = c; bus.in_valid = 1'b1;
    #1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    else         model_accept(x, y, f, l, s, c);
    @(negedge clk);
  endtask

  // Output monitor: compares every popped result word with the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_sum",      bus.out_sum,      e.sum);
        chk("out_idx",      bus.out_idx,      e.idx);
        chk("out_last",     bus.out_last,     e.last);
        chk("out_carry",    bus.out_carry,    e.carry);
        chk("out_overflow", bus.out_overflow, e.ovf);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_first = 1'b0;
    bus.in_last = 1'b0; bus.in_sub = 1'b0; bus.in_cin = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid",    bus.out_valid,    1'b0);
    chk("rst_out_sum",      bus.out_sum,      8'h00);
    chk("rst_out_idx",      bus.out_idx,      2'd0);
    chk("rst_out_last",     bus.out_last,     1'b0);
    chk("rst_out_carry",    bus.out_carry,    1'b0);
    chk("rst_out_overflow", bus.out_overflow, 1'b0);
    chk("rst_seq_err",      seq_err,          1'b0);
    chk("rst_in_ready",     bus.in_ready,     1'b1);
    rst = 1'b0;
    @(negedge clk);

    // 1: single word 0x7F+0x01 -> 0x80, signed overflow
    send(8'h7F, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #1 chk("t1_latency_valid", bus.out_valid, 1'b1);
    @(negedge clk);

    // 2: 0x00FF + 0x0001, back-to-back words
    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("t2_w0_valid", bus.out_valid, 1'b1);
    send(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("t2_w1_no_bubble", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // 3: 0x0100 - 0x0001
    send(8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    send(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // 4: backpressure between words of 0x12FF + 0x0001
    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_x = 8'h12; bus.in_y = 8'h00; bus.in_first = 1'b0; bus.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_in_ready_low", bus.in_ready, 1'b0);
      chk("t4_out_valid_held", bus.out_valid, 1'b1);
      chk("t4_out_sum_held", bus.out_sum, sb[0].sum);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(8'h12, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // 5: over-length op, 0x80+0x80 words with no last
    for (int i = 0; i < 5; i++) begin
      send(8'h80, 8'h80, (i == 0), 1'b0, 1'b0, 1'b0);
      #1 chk("t5_seq_err", seq_err, m_err);
    end
    send(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // 6: reset between words; pending word dropped, next word is first
    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_rst_out_valid", bus.out_valid, 1'b0);
    chk("t6_rst_seq_err", seq_err, 1'b0);
    sb.delete();
    m_busy = 1'b0; m_carry = 1'b0; m_sub = 1'b0; m_idx = 0; m_err = 1'b0;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;

    // drain
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
